input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 92 +++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Input conditioner for the board's push-buttons and slide-switches.
// Every raw pin passes through a two-flop synchronizer. Switch levels are
// only synchronized. Button levels are also debounced, and they produce
// press pulses and sticky press flags for the GPIO block.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_raw,
  input  logic [15:0] sw_raw,
  input  logic [3:0]  event_clear,
  output logic [3:0]  btn_stable,
  output logic [3:0]  btn_press,
  output logic [3:0]  btn_event,
  output logic [15:0] sw_sync
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer stages. Raw pins feed only the s1 flops.
  logic [3:0]  btn_s1_q, btn_s2_q;
  logic [15:0] sw_s1_q, sw_s2_q;

  // Debounce state, one counter per button.
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            stable_q, stable_d;
  logic [3:0]            press_q, press_d;
  logic [3:0]            event_q, event_d;

  // Two-flop synchronizers for every button and switch pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make s2 take the old s1, not the new one.
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Debounce qualification, press detection and sticky event flags.
  always_comb begin
    // NOTE: defaults come first so that no path leaves a signal unassigned and infers a latch.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn_s2_q[i] == stable_q[i]) begin
        // Level agrees with the accepted one. A bounce restarts qualification.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        // The level has held long enough. Accept it and pulse on a rising edge only.
        stable_d[i] = btn_s2_q[i];
        cnt_d[i]    = '0;
        press_d[i]  = btn_s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    // Setting the flag wins over a clear that arrives at the same edge.
    event_d = press_d | (event_q & ~event_clear);
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the counters are reset too, so a partial count is discarded and qualification restarts from zero.
      cnt_q    <= '0;
      stable_q <= '0;
      press_q  <= '0;
      event_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      event_q  <= event_d;
    end
  end

  assign btn_stable = stable_q;
  assign btn_press  = press_q;
  assign btn_event  = event_q;
  assign sw_sync    = sw_s2_q;

endmodule
